// File: rtl/write_data_mask_if.sv
// Request/result bundle for the store-path byte-merge unit.
// master drives the merge request; slave (the merge unit) returns the registered line.
interface write_data_mask_if #(
  parameter int WORDS      = 4,
  parameter int WORD_BYTES = 4
);
  localparam int SEL_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int WORD_W = WORD_BYTES * 8;
  localparam int LINE_W = WORDS * WORD_W;

  logic              in_valid;
  logic [SEL_W-1:0]  word_s;
  logic [WORD_BYTES-1:0] mask;
  logic [WORD_W-1:0] w_data;
  logic [LINE_W-1:0] old_data;
  logic [LINE_W-1:0] new_data;
  logic              out_valid;

  modport master (
    output in_valid, word_s, mask, w_data, old_data,
    input  new_data, out_valid
  );

  modport slave (
    input  in_valid, word_s, mask, w_data, old_data,
    output new_data, out_valid
  );
endinterface

// File: rtl/write_data_mask.sv
// Byte-masked write-merge of one store word into a cache line, registered with one cycle latency.
module write_data_mask #(
  parameter int WORDS      = 4,
  parameter int WORD_BYTES = 4
) (
  input logic              clk,
  input logic              rst_n,
  write_data_mask_if.slave bus
);
  localparam int SEL_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int WORD_W = WORD_BYTES * 8;
  localparam int LINE_W = WORDS * WORD_W;

  // Handshake: a request is taken on every rising edge where in_valid is high
  // (no ready, no backpressure); out_valid is high for exactly the cycle after.
  logic [LINE_W-1:0] merged;

  always_comb begin
    merged = bus.old_data;
    for (int k = 0; k < WORDS; k++) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (bus.word_s == SEL_W'(k) && bus.mask[i]) begin
          merged[(k*WORD_BYTES + i)*8 +: 8] = bus.w_data[i*8 +: 8];
        end
      end
    end
  end

  // new_data holds across idle cycles; only out_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.new_data  <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.new_data <= merged;
      end
    end
  end
endmodule

// File: tb/tb_write_data_mask.sv
// Self-checking bench for write_data_mask: directed store-merge cases plus a random scoreboard run.
module tb_write_data_mask;
  logic clk;
  logic rst_n;

  write_data_mask_if #(.WORDS(4), .WORD_BYTES(4)) bus ();

  write_data_mask #(.WORDS(4), .WORD_BYTES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  localparam logic [127:0] OLD = 128'h11111111_22222222_33333333_44444444;
  localparam logic [31:0]  WD  = 32'h88888888;

  int n_tests = 0;
  int n_fail  = 0;
  logic [127:0] exp_q[$];
  logic [127:0] held;

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] ref_merge(input logic [1:0] ws, input logic [3:0] m,
                                             input logic [31:0] wd, input logic [127:0] od);
    logic [127:0] bm;
    logic [127:0] rep;
    bm = '0;
    for (int i = 0; i < 4; i++)
      if (m[i]) bm[ws*32 + i*8 +: 8] = 8'hff;
    rep = {4{wd}};
    return (od & ~bm) | (rep & bm);
  endfunction

  // Called just after a rising edge: drive one cycle of inputs, then check the result
  // that appears after the next edge.
  task automatic step(input string tag, input logic v, input logic [1:0] ws, input logic [3:0] m,
                      input logic [31:0] wd, input logic [127:0] od, input logic [127:0] exp);
    logic [127:0] e;
    bus.in_valid = v;
    bus.word_s   = ws;
    bus.mask     = m;
    bus.w_data   = wd;
    bus.old_data = od;
    if (v) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (v) begin
      check({tag, "_valid"}, 128'(bus.out_valid), 128'(1));
      if (exp_q.size() == 0) begin
        check({tag, "_queue"}, 128'(0), 128'(1));
      end else begin
        e = exp_q.pop_front();
        held = e;
        check(tag, bus.new_data, e);
      end
    end else begin
      check({tag, "_valid"}, 128'(bus.out_valid), 128'(0));
      check({tag, "_hold"}, bus.new_data, held);
    end
  endtask

  task automatic rand_inputs();
    bus.in_valid = 1'b1;
    bus.word_s   = 2'($urandom_range(0, 3));
    bus.mask     = 4'($urandom_range(0, 15));
    bus.w_data   = $urandom;
    bus.old_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    logic v;
    logic [1:0] ws;
    logic [3:0] m;
    logic [31:0] wd;
    logic [127:0] od;

    // reset: asynchronous clear, nothing captured while held
    rst_n = 1'b1;
    rand_inputs();
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_data", bus.new_data, '0);
    check("rst_async_valid", 128'(bus.out_valid), 128'(0));
    for (int c = 0; c < 3; c++) begin
      rand_inputs();
      @(posedge clk);
      #1;
      check("rst_hold_data", bus.new_data, '0);
      check("rst_hold_valid", 128'(bus.out_valid), 128'(0));
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    held = '0;
    @(posedge clk);
    #1;

    // full-word sweep, back-to-back
    step("sweep0", 1'b1, 2'd0, 4'b1111, WD, OLD, 128'h11111111_22222222_33333333_88888888);
    step("sweep1", 1'b1, 2'd1, 4'b1111, WD, OLD, 128'h11111111_22222222_88888888_44444444);
    step("sweep2", 1'b1, 2'd2, 4'b1111, WD, OLD, 128'h11111111_88888888_33333333_44444444);
    step("sweep3", 1'b1, 2'd3, 4'b1111, WD, OLD, 128'h88888888_22222222_33333333_44444444);

    // partial and non-contiguous masks
    step("mask0101", 1'b1, 2'd0, 4'b0101, WD, OLD, 128'h11111111_22222222_33333333_44884488);
    step("mask1000", 1'b1, 2'd3, 4'b1000, WD, OLD, 128'h88111111_22222222_33333333_44444444);
    step("mask1010_w2", 1'b1, 2'd2, 4'b1010, 32'hA1B2C3D4, OLD,
         128'h11111111_A122C322_33333333_44444444);

    // empty mask
    step("mask0_w1", 1'b1, 2'd1, 4'b0000, WD, OLD, OLD);
    step("mask0_w3", 1'b1, 2'd3, 4'b0000, WD, OLD, OLD);

    // idle hold with every input changed
    step("idle_a", 1'b0, 2'd2, 4'b1111, 32'hDEADBEEF, ~OLD, '0);
    step("idle_b", 1'b0, 2'd0, 4'b0110, 32'h12345678, 128'h0, '0);
    step("after_idle", 1'b1, 2'd1, 4'b0011, WD, OLD, 128'h11111111_22222222_33338888_44444444);

    // reset mid-stream discards the pending request
    bus.in_valid = 1'b1;
    bus.word_s   = 2'd0;
    bus.mask     = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_data", bus.new_data, '0);
    check("midrst_valid", 128'(bus.out_valid), 128'(0));
    exp_q.delete();
    held = '0;
    @(posedge clk);
    #1;
    check("midrst_edge_data", bus.new_data, '0);
    check("midrst_edge_valid", 128'(bus.out_valid), 128'(0));
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("post_rst", 1'b1, 2'd2, 4'b1111, WD, OLD, 128'h11111111_88888888_33333333_44444444);

    // randomized against the reference model
    for (int c = 0; c < 1000; c++) begin
      v  = ($urandom_range(0, 3) != 0);
      ws = 2'($urandom_range(0, 3));
      m  = 4'($urandom_range(0, 15));
      wd = $urandom;
      od = {$urandom, $urandom, $urandom, $urandom};
      step("rand", v, ws, m, wd, od, ref_merge(ws, m, wd, od));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
